esc_core_p: RTL and testbench

ESC_CORE_P -- requirements
Module: esc_core_p

---
 rtl/esc_core_p.sv | 149 ++++++++++++++
 tb/tb_esc_core_p.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_core_p.sv
// Accumulator-based micro-core: fetches instructions from a single handshaked memory port,
// executes ADD/SUB/AND/LD/ST plus jumps, and stops on HALT until reset.
module esc_core_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry_out,
    output logic              halted
);

    generate
        if (DATA_W < OPC_W + ADDR_W) begin : g_bad_widths
            $error("esc_core_p: DATA_W must be >= OPC_W + ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JN   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(8);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    // The IR is kept as its two meaningful fields; the middle bits are never needed.
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [ADDR_W-1:0]   opd_q, opd_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic                halted_q, halted_d;
    logic [DATA_W:0]     sum;

    assign sum = {1'b0, acc_q} + {1'b0, mem_rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        opc_d   = opc_q;
        opd_d   = opd_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    opc_d   = mem_rdata[DATA_W-1 -: OPC_W];
                    opd_d   = mem_rdata[ADDR_W-1:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (opc_q)
                    OP_ADD, OP_SUB, OP_AND, OP_LD, OP_ST: state_d = S_MEM;
                    OP_JMP:  pc_d = opd_q;
                    OP_JZ:   if (acc_q == '0) pc_d = opd_q;
                    OP_JN:   if (acc_q[DATA_W-1]) pc_d = opd_q;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
                    case (opc_q)
                        OP_ADD: {carry_d, acc_d} = sum;
                        OP_SUB: begin
                            carry_d = (acc_q < mem_rdata);
                            acc_d   = acc_q - mem_rdata;
                        end
                        OP_AND:  acc_d = acc_q & mem_rdata;
                        OP_LD:   acc_d = mem_rdata;
                        default: ;
                    endcase
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    // Bus strobes and halted are registered alongside the next state, so mem_ack has no
    // combinational path to them and reset clears them at once.
    always_comb begin
        mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d  = (state_d == S_MEM) && (opc_d == OP_ST);
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_START;
            pc_q      <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            opc_q     <= '0;
            opd_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            opc_q     <= opc_d;
            opd_q     <= opd_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            halted_q  <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = (state_q == S_MEM) ? opd_q : pc_q;
    assign mem_wdata = acc_q;
    assign pc_out    = pc_q;
    assign acc_out   = acc_q;
    assign carry_out = carry_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_esc_core_p.sv
// Bench for esc_core_p: memory model with programmable ack latency, directed programs,
// a vector table of arithmetic cases and random programs checked against an ISA model.
module tb_esc_core_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;
    logic [7:0]  pc_out;
    logic [15:0] acc_out;
    logic        carry_out, halted;

    esc_core_p dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc_out(pc_out), .acc_out(acc_out), .carry_out(carry_out), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] tb_mem [256];
    logic [15:0] m_mem  [256];
    int          delay = 0;
    int          cnt = 0;
    bit          spur_en = 1'b0;
    bit          ack_real = 1'b0;
    logic [7:0]  st_addr, cap_addr;
    logic        st_we, cap_we;
    logic [15:0] st_wd, cap_wd;
    logic [7:0]  q_addr [$];
    logic        q_we [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory: acks after 'delay' wait cycles, applies writes once the ack has been taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            cnt      = 0;
            ack_real = 1'b0;
        end else begin
            if (ack_real) begin
                if (cap_we) tb_mem[cap_addr] = cap_wd;
                ack_real = 1'b0;
                cnt      = 0;
            end
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            if (mem_req) begin
                if (cnt == 0) begin
                    st_addr = mem_addr; st_we = mem_we; st_wd = mem_wdata;
                end else begin
                    check("hold_addr", mem_addr, st_addr);
                    check("hold_we", mem_we, st_we);
                    check("hold_wdata", mem_wdata, st_wd);
                end
                if (cnt >= delay) begin
                    mem_ack   = 1'b1;
                    ack_real  = 1'b1;
                    mem_rdata = tb_mem[mem_addr];
                    cap_addr  = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
                    q_addr.push_back(mem_addr);
                    q_we.push_back(mem_we);
                end else begin
                    cnt++;
                end
            end else if (spur_en) begin
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic begin_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0;
        q_addr.delete();
        q_we.delete();
    endtask

    task automatic release_reset(input int d, input bit spur);
        delay   = d;
        spur_en = spur;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_halt(input int limit, output int cyc);
        cyc = 0;
        while (!halted && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (!halted) check("halt_timeout", 32'(cyc), 32'(limit + 1));
    endtask

    // ISA-level reference: executes instructions one at a time and totals their cycle cost.
    task automatic model_run(input int d, output logic [15:0] acc, output logic c,
                             output logic [7:0] pc, output int cyc, output bit hl);
        logic [15:0] ir, v;
        logic [16:0] s;
        logic [3:0]  op;
        logic [7:0]  a;
        acc = 0; c = 0; pc = 0; cyc = 1; hl = 0;
        for (int n = 0; n < 1000 && !hl; n++) begin
            ir  = m_mem[pc];
            pc  = pc + 8'd1;
            cyc += d + 2;
            op  = ir[15:12];
            a   = ir[7:0];
            v   = m_mem[a];
            if (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd7) cyc += d + 1;
            case (op)
                4'd0: begin s = {1'b0, acc} + {1'b0, v}; c = s[16]; acc = s[15:0]; end
                4'd1: m_mem[a] = acc;
                4'd2: acc = v;
                4'd3: pc = a;
                4'd4: begin c = (acc < v); acc = acc - v; end
                4'd5: if (acc == 16'h0) pc = a;
                4'd6: if (acc[15]) pc = a;
                4'd7: acc = acc & v;
                4'd8: hl = 1;
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [3:0]  op1;
        logic [15:0] b;
        logic [3:0]  op2;
        logic [15:0] c;
        logic [15:0] e_acc;
        logic        e_c;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc;
        logic [15:0] m_acc;
        logic        m_c, m_hl;
        logic [7:0]  m_pc, pc_hold;
        int          m_cyc, k, sel, nmis, d;
        logic [3:0]  op;
        logic [7:0]  opd;
        logic [15:0] acc_hold;

        vecs[0] = '{16'hFFFF, 4'h0, 16'h0001, 4'h7, 16'h1234, 16'h0000, 1'b1};
        vecs[1] = '{16'h8000, 4'h0, 16'h8000, 4'h2, 16'h1234, 16'h1234, 1'b1};
        vecs[2] = '{16'h0005, 4'h4, 16'h0007, 4'h0, 16'h0000, 16'hFFFE, 1'b0};
        vecs[3] = '{16'h0007, 4'h4, 16'h0005, 4'h7, 16'hFFFF, 16'h0002, 1'b0};
        vecs[4] = '{16'hF0F0, 4'h7, 16'h3C3C, 4'h1, 16'h5555, 16'h3030, 1'b0};
        vecs[5] = '{16'h0000, 4'h4, 16'h0001, 4'h4, 16'h0000, 16'hFFFF, 1'b0};
        vecs[6] = '{16'h1234, 4'h9, 16'h0000, 4'h0, 16'hEDCC, 16'h0000, 1'b1};
        vecs[7] = '{16'hFFFF, 4'h0, 16'hFFFF, 4'h4, 16'hFFFF, 16'hFFFF, 1'b1};

        // Reset state
        begin_reset();
        #1;
        check("rst_pc", pc_out, 8'h00);
        check("rst_acc", acc_out, 16'h0);
        check("rst_carry", carry_out, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);

        // Reference program, zero-wait and 3-cycle ack delay
        for (int pass = 0; pass < 2; pass++) begin
            begin_reset();
            tb_mem[0] = 16'h2010; tb_mem[1] = 16'h0011; tb_mem[2] = 16'h1012; tb_mem[3] = 16'h8000;
            tb_mem[16'h10] = 16'h0005; tb_mem[16'h11] = 16'h0007;
            release_reset(pass * 3, 1'b0);
            run_halt(200, cyc);
            @(negedge clk); #1;
            check("prog_cycles", 32'(cyc), (pass == 0) ? 32'd12 : 32'd33);
            check("prog_mem12", tb_mem[8'h12], 16'h000C);
            check("prog_halted", halted, 1'b1);
            check("prog_pc", pc_out, 8'h04);
            check("prog_acc", acc_out, 16'h000C);
            check("prog_st_addr", (q_addr.size() > 5) ? q_addr[5] : 8'hXX, 8'h12);
            check("prog_st_we", (q_we.size() > 5) ? q_we[5] : 1'bx, 1'b1);
            pc_hold = pc_out; acc_hold = acc_out;
            repeat (5) @(negedge clk);
            check("halt_req", mem_req, 1'b0);
            check("halt_freeze", {pc_out, acc_out}, {pc_hold, acc_hold});
        end

        // Arithmetic vector table: LD a; op1 b; op2 c; HALT
        foreach (vecs[i]) begin
            begin_reset();
            tb_mem[0] = 16'h2080;
            tb_mem[1] = {vecs[i].op1, 4'h0, 8'h81};
            tb_mem[2] = {vecs[i].op2, 4'h0, 8'h82};
            tb_mem[3] = 16'h8000;
            tb_mem[8'h80] = vecs[i].a; tb_mem[8'h81] = vecs[i].b; tb_mem[8'h82] = vecs[i].c;
            release_reset(i % 3, 1'b1);
            run_halt(200, cyc);
            check($sformatf("vec%0d_acc", i), acc_out, vecs[i].e_acc);
            check($sformatf("vec%0d_carry", i), carry_out, vecs[i].e_c);
        end

        // ADD to zero then JZ taken
        begin_reset();
        tb_mem[0] = 16'h2080; tb_mem[1] = 16'h0081; tb_mem[2] = 16'h5020; tb_mem[3] = 16'h8000;
        tb_mem[8'h20] = 16'h8000; tb_mem[8'h80] = 16'hFFFF; tb_mem[8'h81] = 16'h0001;
        release_reset(0, 1'b0);
        run_halt(200, cyc);
        check("jz_acc", acc_out, 16'h0000);
        check("jz_carry", carry_out, 1'b1);
        check("jz_target", (q_addr.size() > 5) ? q_addr[5] : 8'hXX, 8'h20);

        // SUB then JN, taken and not taken
        for (int t = 0; t < 2; t++) begin
            begin_reset();
            tb_mem[0] = 16'h2080; tb_mem[1] = 16'h4081; tb_mem[2] = 16'h6030; tb_mem[3] = 16'h8000;
            tb_mem[8'h30] = 16'h8000;
            tb_mem[8'h80] = (t == 0) ? 16'h0005 : 16'h0007;
            tb_mem[8'h81] = (t == 0) ? 16'h0007 : 16'h0005;
            release_reset(1, 1'b0);
            run_halt(200, cyc);
            check("jn_acc", acc_out, (t == 0) ? 16'hFFFE : 16'h0002);
            check("jn_carry", carry_out, (t == 0) ? 1'b1 : 1'b0);
            check("jn_next", (q_addr.size() > 5) ? q_addr[5] : 8'hXX, (t == 0) ? 8'h30 : 8'h03);
        end

        // Reset during an unacknowledged store
        begin_reset();
        tb_mem[0] = 16'h1012; tb_mem[1] = 16'h8000; tb_mem[8'h12] = 16'hABCD;
        release_reset(10, 1'b0);
        k = 0;
        while (!(mem_req && mem_we) && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("st_wait", {31'd0, mem_req && mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_we", mem_we, 1'b0);
        check("mid_rst_pc", pc_out, 8'h00);
        @(negedge clk); @(negedge clk); #1;
        check("mid_rst_mem", tb_mem[8'h12], 16'hABCD);
        q_addr.delete(); q_we.delete();
        release_reset(0, 1'b0);
        run_halt(200, cyc);
        check("post_rst_fetch", (q_addr.size() > 0) ? q_addr[0] : 8'hXX, 8'h00);
        check("post_rst_pc", pc_out, 8'h02);

        // Random forward-branching programs against the ISA model
        for (int r = 0; r < 40; r++) begin
            begin_reset();
            k = $urandom_range(3, 20);
            for (int i = 0; i < k; i++) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd4; 4: op = 4'd7;
                    5: op = 4'd3; 6: op = 4'd5; 7: op = 4'd6; 8: op = 4'($urandom_range(9, 15));
                    default: op = 4'd2;
                endcase
                if (sel >= 5 && sel <= 7) opd = 8'($urandom_range(i + 1, k));
                else opd = 8'h80 + 8'($urandom_range(0, 15));
                tb_mem[i] = {op, 4'($urandom), opd};
            end
            tb_mem[k] = {4'h8, 4'($urandom), 8'($urandom)};
            for (int i = 8'h80; i < 8'h90; i++) begin
                case ($urandom_range(0, 4))
                    0: tb_mem[i] = 16'h0000; 1: tb_mem[i] = 16'hFFFF;
                    2: tb_mem[i] = 16'h8000; 3: tb_mem[i] = 16'h0001;
                    default: tb_mem[i] = 16'($urandom);
                endcase
            end
            for (int i = 0; i < 256; i++) m_mem[i] = tb_mem[i];
            d = $urandom_range(0, 3);
            model_run(d, m_acc, m_c, m_pc, m_cyc, m_hl);
            release_reset(d, 1'b1);
            run_halt(3000, cyc);
            @(negedge clk); #1;
            check("rnd_acc", acc_out, m_acc);
            check("rnd_carry", carry_out, m_c);
            check("rnd_pc", pc_out, m_pc);
            check("rnd_cycles", 32'(cyc), 32'(m_cyc));
            nmis = 0;
            for (int i = 0; i < 256; i++) if (tb_mem[i] !== m_mem[i]) nmis++;
            check("rnd_mem", 32'(nmis), 32'd0);
        end

        // JMP to the top address; PC wraps to 0
        begin_reset();
        tb_mem[0] = 16'h30FF; tb_mem[8'hFF] = 16'hF000;
        release_reset(0, 1'b0);
        k = 0;
        while (q_addr.size() < 5 && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        check("wrap_txns", 32'(q_addr.size() >= 5), 32'd1);
        check("wrap_fetch_ff", (q_addr.size() > 1) ? q_addr[1] : 8'hXX, 8'hFF);
        check("wrap_fetch_00", (q_addr.size() > 2) ? q_addr[2] : 8'hXX, 8'h00);
        check("wrap_halted", halted, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
